song_player: RTL
================

# song_player

Autoplay sequencer for the piano's study and demo modes. It walks a selected song's note table one entry at a time. Each entry's octave, note and length are presented to the sound generator for a beat-timed duration, followed by a one-beat gap. The block is the producer side of the note path: it generates the note stream that the study-mode checker otherwise receives from the keys, and it feeds the same sound/light logic.

## Interface
Parameters:
- CNT_BITS, 6: width of the song entry index (max 64 entries per song)
- DUR_BITS, 4: width of the beat duration counter

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; synchronous, active-high (1 = reset), name kept per codebase port naming
- en  input  1  mode enable; low forces IDLE synchronously, same as reset
- start  input  1  one-cycle pulse; begins playback from entry 0
- pause  input  1  level; freezes playback in place
- tick  input  1  one-cycle beat strobe derived from system_clock
- song_sel  input  SONG_BITS  song to play; sampled on accepted start only
- rom_song  output  SONG_BITS  latched song number to note table
- rom_addr  output  CNT_BITS  entry index to note table
- rom_octave  input  OCTAVE_BITS  entry octave, valid 1 cycle after rom_addr
- rom_note  input  NOTE_BITS  entry note; 0 = rest
- rom_length  input  LENGTH_BITS  entry length code
- rom_track  input  CNT_BITS  index of the song's last entry
- octave, note, length  output  OCTAVE/NOTE/LENGTH_BITS  current entry to sound generator
- note_valid  output  1  sound generator enable
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at end of song

## Operation
- States: IDLE, FETCH, WAIT_ROM, PLAY, GAP.
- IDLE: start (with en=1) latches song_sel into rom_song, clears idx to 0 and moves to FETCH.
- FETCH: drive rom_addr = idx, then move to WAIT_ROM.
- WAIT_ROM: latch rom_octave, rom_note, rom_length and rom_track into output registers. Load dur = 1 << length code (0→1, 1→2, 2→4, 3→8 ticks) and move to PLAY.
- PLAY: note_valid = (note != 0) & ~pause. Each tick with pause=0 decrements dur. At dur reaching 0, move to GAP.
- GAP: note_valid = 0; wait one tick with pause=0. Then:
  - if idx < track: idx+1, move to FETCH.
  - else: end of song (see Configuration).
- start while busy: ignored. Changes to song_sel after start: ignored.
- rom_track = 0: a single-entry song plays normally.
- Index arithmetic is unsigned CNT_BITS. idx never exceeds the latched track.

## Timing
- Reset / en=0: state IDLE; idx=0; octave=3'b100; note=0; length=0; note_valid=0; busy=0; done=0; rom_song=0; rom_addr=0.
- Latency from start to note_valid high is 3 cycles: start at cycle 0, FETCH at 1, WAIT_ROM at 2, PLAY at 3.
- Ticks arriving in FETCH or WAIT_ROM are dropped; they do not count toward the duration.
- A tick in the same cycle the block enters PLAY is not counted.
- Note audible time is exactly dur ticks, plus 0–1 cycles of phase slip.
- pause raised mid-PLAY: note_valid drops next cycle; dur holds. On release, playback resumes with the remaining dur.
- Reset or en=0 in any state: IDLE next cycle. No done pulse.
- Reset and start in the same cycle: reset wins.
- done is registered and asserts in the cycle the FSM leaves GAP on the last entry.

## Configuration
- Macro: STDY_PLAYER_LOOP_EN.
- Defined: at end of song, idx wraps to 0 and the FSM moves to FETCH. done still pulses once per pass, and busy stays high.
- Undefined: at end of song, the FSM moves to IDLE, done pulses, and busy falls in the same cycle as done.

## Structure
- Shared constants come from the existing constants header: SONG_BITS, OCTAVE_BITS, NOTE_BITS, LENGTH_BITS and the default octave 3'b100.
- Add to that header a state encoding for the five states and the length-to-ticks mapping.
- One natural sub-module: beat_counter. It loads a DUR_BITS count, decrements on tick & ~pause, and flags zero. The GAP wait reuses it with a load of 1.
- The note table itself is external, and the existing song table sits behind a one-cycle register.

## Test plan
- Reset then start, song with track=2 and lengths 0, 1, 2 → note_valid high for 1, 2 and 4 ticks respectively, one-tick gap after each. Without LOOP_EN: done pulses once, busy falls.
- Entry with note=0, length=1 → note_valid stays 0 for 2 ticks, and idx still advances.
- pause asserted after 1 tick of a length-2 note, held 5 ticks, then released → 3 more ticks of note_valid. No idx change while paused.
- start again mid-PLAY with a different song_sel → ignored; rom_song unchanged.
- rst_n (=1) asserted during PLAY at idx=1 → next cycle IDLE, all outputs at reset values, no done.
- With STDY_PLAYER_LOOP_EN, track=0, length 0 → repeating pattern of 1 tick note, 1 tick gap. done pulses every pass, and busy never falls.

Source files
------------

// File: rtl/song_player_pkg.sv
// song_player_pkg: shared widths, default octave, FSM states and length-to-ticks mapping
package song_player_pkg;
  localparam int SONG_BITS   = 2;
  localparam int OCTAVE_BITS = 3;
  localparam int NOTE_BITS   = 4;
  localparam int LENGTH_BITS = 2;
  localparam logic [OCTAVE_BITS-1:0] DEF_OCTAVE = 3'b100;
  typedef enum logic [2:0] {IDLE, FETCH, WAIT_ROM, PLAY, GAP} state_t;
  function automatic logic [7:0] len_ticks(input logic [LENGTH_BITS-1:0] code);
    return 8'd1 << code;
  endfunction
endpackage

// File: rtl/song_player_beat_counter.sv
// song_player_beat_counter: loadable down-counter stepped by unpaused beat ticks
module song_player_beat_counter #(
  parameter int DUR_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [DUR_BITS-1:0] load_val,
  input  logic                tick,
  input  logic                pause,
  output logic                zero
);
  logic [DUR_BITS-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && !pause && cnt != '0) cnt <= cnt - DUR_BITS'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/song_player.sv
// song_player: walks a song's note table, playing each entry for its beat count then a one-beat gap
// STDY_PLAYER_LOOP_EN: when defined the song restarts from entry 0 instead of returning to IDLE
module song_player
  import song_player_pkg::*;
#(
  parameter int CNT_BITS = 6,
  parameter int DUR_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   tick,
  input  logic [SONG_BITS-1:0]   song_sel,
  output logic [SONG_BITS-1:0]   rom_song,
  output logic [CNT_BITS-1:0]    rom_addr,
  input  logic [OCTAVE_BITS-1:0] rom_octave,
  input  logic [NOTE_BITS-1:0]   rom_note,
  input  logic [LENGTH_BITS-1:0] rom_length,
  input  logic [CNT_BITS-1:0]    rom_track,
  output logic [OCTAVE_BITS-1:0] octave,
  output logic [NOTE_BITS-1:0]   note,
  output logic [LENGTH_BITS-1:0] length,
  output logic                   note_valid,
  output logic                   busy,
  output logic                   done
);
  state_t state;
  logic [CNT_BITS-1:0] idx, track;
  logic load, zero, clr;
  logic [DUR_BITS-1:0] load_val;
  assign clr = rst_n || !en;
  assign rom_addr = idx;
  // the same counter times the note and then the one-beat gap
  assign load = state == WAIT_ROM || (state == PLAY && zero);
  assign load_val = state == WAIT_ROM ? DUR_BITS'(len_ticks(rom_length)) : DUR_BITS'(1);
  song_player_beat_counter #(.DUR_BITS(DUR_BITS)) u_beat (
    .clk(clk), .rst(clr), .load(load), .load_val(load_val),
    .tick(tick), .pause(pause), .zero(zero)
  );
  always_ff @(posedge clk)
    if (clr) begin
      state <= IDLE;
      idx <= '0;
      track <= '0;
      rom_song <= '0;
      octave <= DEF_OCTAVE;
      note <= '0;
      length <= '0;
      note_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          rom_song <= song_sel;
          idx <= '0;
          busy <= 1'b1;
          state <= FETCH;
        end
        FETCH: state <= WAIT_ROM;
        WAIT_ROM: begin
          octave <= rom_octave;
          note <= rom_note;
          length <= rom_length;
          track <= rom_track;
          note_valid <= rom_note != '0 && !pause;
          state <= PLAY;
        end
        PLAY: begin
          note_valid <= !zero && note != '0 && !pause;
          if (zero) state <= GAP;
        end
        GAP: if (zero) begin
          if (idx < track) begin
            idx <= idx + CNT_BITS'(1);
            state <= FETCH;
          end else begin
            done <= 1'b1;
`ifdef STDY_PLAYER_LOOP_EN
            idx <= '0;
            state <= FETCH;
`else
            busy <= 1'b0;
            state <= IDLE;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
